// File: rtl/vedic_dot_accum.sv
// Dot-product accumulator behind the 4x4 Vedic multiplier: sums LEN products
// per result and hands the result downstream over a valid/ready handshake.
module vedic_dot_accum #(
    parameter int P_W   = 8,
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clr,
    input  logic [P_W-1:0]   p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             acc_ovf,
    output logic             busy
);
    localparam int CNT_W = $clog2(LEN + 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ovf, ovf_nxt;
    logic               accept;
    logic [ACC_W:0]     p_ext;
    logic [ACC_W:0]     sum;

    assign p_ready   = ena && (state != DONE);
    assign accept    = p_valid && p_ready;
    assign p_ext     = {{(ACC_W + 1 - P_W){1'b0}}, p_in};
    // One bit wider than the accumulator so the carry out feeds the sticky flag.
    assign sum       = {1'b0, acc} + p_ext;
    assign acc_out   = acc;
    assign acc_valid = (state == DONE);
    assign acc_ovf   = ovf;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        if (clr) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_nxt   = p_ext[ACC_W-1:0];
                        cnt_nxt   = CNT_W'(1);
                        ovf_nxt   = 1'b0;
                        state_nxt = (LEN == 1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_nxt = sum[ACC_W-1:0];
                        ovf_nxt = ovf | sum[ACC_W];
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(LEN - 1))
                            state_nxt = DONE;
                    end
                end
                DONE: begin
                    // Overflow flag survives the handshake; the next vector's first accept clears it.
                    if (acc_ready) begin
                        state_nxt = IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule
